// File: rtl/sobol_pkg.sv
// Shared types, widths and helpers for the Sobol FP16 scheduler:
// Gray-code step index and INT32 to unsigned FP16 conversion.
package sobol_pkg;

    typedef enum logic [1:0] {IDLE, STEP, OUT} state_t;

    localparam int VEC_W   = 32;
    localparam int VEC_CNT = 32;
    localparam int FP16_W  = 16;
    localparam int EXP_W   = 4;
    localparam int MANT_W  = 12;
    localparam int IDX_W   = $clog2(VEC_CNT);

    // Index of the lowest clear bit of the counter (direction vector select).
    function automatic logic [IDX_W-1:0] lowest_zero(input logic [VEC_W-1:0] n);
        logic [IDX_W-1:0] c;
        c = '0;
        for (int i = VEC_W - 1; i >= 0; i--)
            if (!n[i]) c = IDX_W'(i);
        return c;
    endfunction

    // Exponent is the leading-one position (floored at 11), mantissa is the
    // 12 bits starting at that position.
    function automatic logic [FP16_W-1:0] to_fp16(input logic [VEC_W-1:0] x);
        int mso;
        logic [VEC_W-1:0] sh;
        mso = MANT_W - 1;
        for (int i = MANT_W; i < VEC_W; i++)
            if (x[i]) mso = i;
        sh = x >> (mso - (MANT_W - 1));
        return {EXP_W'(mso), sh[MANT_W-1:0]};
    endfunction

endpackage

// File: rtl/sobol_fp16_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after ptr,
// wrapping around; returns both one-hot and binary grant.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic found;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx;
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/sobol_fp16_scheduler.sv
// Time-shares one Gray-code Sobol step engine and FP16 converter among
// NUM_REQ requesters, each owning its own Sobol dimension.
module sobol_fp16_scheduler
    import sobol_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [$clog2(NUM_REQ)-1:0] cfg_dim,
    input  logic [4:0]                 cfg_idx,
    input  logic [31:0]                cfg_vec,
    input  logic                       cfg_rewind,
    input  logic [NUM_REQ-1:0]         req,
    output logic                       busy,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(NUM_REQ)-1:0] out_id,
    output logic [15:0]                out_data
);

    localparam int ID_W = $clog2(NUM_REQ);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   g_q, rr_ptr, grant_idx;
    logic [NUM_REQ-1:0] grant_oh;

    logic [VEC_W-1:0]  n_q [NUM_REQ];
    logic [VEC_W-1:0]  x_q [NUM_REQ];
    logic [VEC_W-1:0]  v_q [NUM_REQ][VEC_CNT];
    logic [VEC_W-1:0]  n_cur, n_nxt, x_nxt;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req),
        .ptr       (rr_ptr),
        .grant     (grant_oh),
        .grant_idx (grant_idx)
    );

    // Step engine for the granted dimension; an all-ones counter wraps to the origin.
    always_comb begin
        n_cur = n_q[g_q];
        n_nxt = '0;
        x_nxt = '0;
        if (!(&n_cur)) begin
            n_nxt = n_cur + 1'b1;
            x_nxt = x_q[g_q] ^ v_q[g_q][lowest_zero(n_cur)];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|grant_oh) state_d = STEP;
            STEP:    state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        out_valid = (state_q == OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g_q      <= '0;
            rr_ptr   <= '0;
            out_id   <= '0;
            out_data <= '0;
        end else begin
            if (state_q == IDLE && |grant_oh) g_q <= grant_idx;
            if (state_q == STEP) begin
                out_data <= to_fp16(x_nxt);
                out_id   <= g_q;
            end
            if (state_q == OUT && out_ready)
                rr_ptr <= (int'(g_q) == NUM_REQ - 1) ? '0 : g_q + 1'b1;
        end
    end

    // NOTE: the direction-vector store is reset along with the counters because
    // every dimension must restart from all-zero vectors after rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < NUM_REQ; d++) begin
                n_q[d] <= '0;
                x_q[d] <= '0;
                for (int j = 0; j < VEC_CNT; j++) v_q[d][j] <= '0;
            end
        end else begin
            if (cfg_we && int'(cfg_dim) < NUM_REQ) v_q[cfg_dim][cfg_idx] <= cfg_vec;
            if (state_q == STEP) begin
                n_q[g_q] <= n_nxt;
                x_q[g_q] <= x_nxt;
            end
            // Placed after the step so a same-cycle rewind overrides it.
            if (cfg_rewind && int'(cfg_dim) < NUM_REQ) begin
                n_q[cfg_dim] <= '0;
                x_q[cfg_dim] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sobol_fp16_scheduler.sv
// Self-checking bench: Gray-code closed-form Sobol model compared every cycle,
// plus directed transactions with hand-computed FP16 values.
module tb_sobol_fp16_scheduler;

    localparam int NUM_REQ = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_dim = '0;
    logic [4:0]  cfg_idx = '0;
    logic [31:0] cfg_vec = '0;
    logic        cfg_rewind = 1'b0;
    logic [3:0]  req = '0;
    logic        busy, out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  out_id;
    logic [15:0] out_data;

    int checks = 0;
    int errors = 0;

    sobol_fp16_scheduler #(.NUM_REQ(NUM_REQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_dim    (cfg_dim),
        .cfg_idx    (cfg_idx),
        .cfg_vec    (cfg_vec),
        .cfg_rewind (cfg_rewind),
        .req        (req),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_id     (out_id),
        .out_data   (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mv [NUM_REQ][32];
    logic [31:0] mn [NUM_REQ];
    int          m_age = 0;     // 0 waiting, 1 granted, 2 sample offered
    int          m_g = 0;
    int          m_rr = 0;
    int          exp_id = 0;
    logic [15:0] exp_data = '0;

    // k-th Sobol point: XOR of the vectors selected by the Gray code of k.
    function automatic logic [31:0] sobol_point(input int d, input logic [31:0] k);
        logic [31:0] gray, x;
        gray = k ^ (k >> 1);
        x = '0;
        for (int j = 0; j < 32; j++)
            if (gray[j]) x ^= mv[d][j];
        return x;
    endfunction

    function automatic logic [15:0] fp16_model(input logic [31:0] x);
        int e;
        logic [31:0] m;
        if (x < 32'd4096) return {4'hB, x[11:0]};
        e = 11;
        while ((x >> (e + 1)) != 0) e++;
        m = x >> (e - 11);
        return {4'(e), m[11:0]};
    endfunction

    function automatic int pick(input logic [3:0] r, input int p);
        for (int i = 0; i < NUM_REQ; i++)
            if (r[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_age    <= 0;
            m_rr     <= 0;
            exp_id   <= 0;
            exp_data <= '0;
            for (int d = 0; d < NUM_REQ; d++) begin
                mn[d] <= '0;
                for (int j = 0; j < 32; j++) mv[d][j] <= '0;
            end
        end else begin
            case (m_age)
                0: if (|req) begin
                    m_g   <= pick(req, m_rr);
                    m_age <= 1;
                end
                1: begin
                    mn[m_g]  <= mn[m_g] + 1;
                    exp_data <= fp16_model(sobol_point(m_g, mn[m_g] + 1));
                    exp_id   <= m_g;
                    m_age    <= 2;
                end
                default: if (out_ready) begin
                    m_rr  <= (m_g + 1) % NUM_REQ;
                    m_age <= 0;
                end
            endcase
            if (cfg_we) mv[cfg_dim][cfg_idx] <= cfg_vec;
            if (cfg_rewind) mn[cfg_dim] <= '0;
        end
    end

    always @(negedge clk) begin
        check("model_busy", 32'(busy), 32'(m_age != 0));
        check("model_valid", 32'(out_valid), 32'(m_age == 2));
        if (m_age == 2) begin
            check("model_id", 32'(out_id), 32'(exp_id));
            check("model_data", 32'(out_data), 32'(exp_data));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cfg_write(input int d, input int i, input logic [31:0] v);
        cfg_we = 1'b1; cfg_dim = 2'(d); cfg_idx = 5'(i); cfg_vec = v;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic rewind(input int d);
        cfg_rewind = 1'b1; cfg_dim = 2'(d);
        @(negedge clk);
        cfg_rewind = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int w = 0;
        while (!out_valid && w < 10) begin
            @(negedge clk);
            w++;
        end
        check({nm, "_valid"}, 32'(out_valid), 32'd1);
    endtask

    task automatic txn(input logic [3:0] r, input int eid, input logic [15:0] ed, input string nm);
        req = r;
        @(negedge clk);
        wait_valid(nm);
        check({nm, "_id"}, 32'(out_id), 32'(eid));
        check({nm, "_data"}, 32'(out_data), 32'(ed));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        req = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  rr_ids  [5];
        logic [15:0] rr_data [5];
        int k;
        rr_ids  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rr_data = '{16'hF800, 16'hB123, 16'h0800, 16'h7F00, 16'hFC00};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_id", 32'(out_id), 32'd0);
        check("rst_data", 32'(out_data), 32'h0);

        cfg_write(0, 0, 32'h8000_0000);
        cfg_write(0, 1, 32'h4000_0000);
        cfg_write(1, 0, 32'h0000_0123);
        cfg_write(2, 0, 32'h0001_0000);
        cfg_write(2, 1, 32'h0002_0000);
        cfg_write(3, 0, 32'h00F0_0000);
        cfg_write(3, 1, 32'h0100_0000);

        // All requesters held: round-robin order from pointer 0.
        req = 4'b1111;
        out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 40 && k < 5; c++) begin
            @(negedge clk);
            if (out_valid) begin
                check("rr_id", 32'(out_id), 32'(rr_ids[k]));
                check("rr_data", 32'(out_data), 32'(rr_data[k]));
                k++;
            end
        end
        check("rr_count", 32'(k), 32'd5);
        req = '0;
        @(negedge clk);
        out_ready = 1'b0;

        rewind(0);
        txn(4'b0001, 0, 16'hF800, "d0_p1");
        txn(4'b0001, 0, 16'hFC00, "d0_p2");
        txn(4'b0001, 0, 16'hE800, "d0_p3");

        // Back-pressure: sample must hold and no dimension may advance.
        req = 4'b0100;
        @(negedge clk);
        wait_valid("stall");
        for (int c = 0; c < 5; c++) begin
            check("stall_id", 32'(out_id), 32'd2);
            check("stall_data", 32'(out_data), 32'h1C00);
            check("stall_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        req = '0;
        txn(4'b0100, 2, 16'h1800, "post_stall");

        // Rewind during STEP: sample still delivered, dimension restarts.
        req = 4'b1000;
        @(negedge clk);
        cfg_rewind = 1'b1; cfg_dim = 2'd3;
        @(negedge clk);
        cfg_rewind = 1'b0;
        check("rw_step_valid", 32'(out_valid), 32'd1);
        check("rw_step_data", 32'(out_data), 32'h8F80);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        req = '0;
        txn(4'b1000, 3, 16'h7F00, "rw_restart");

        rewind(1);
        txn(4'b0010, 1, 16'hB123, "rw_d1");

        // Reset while a sample is offered.
        req = 4'b0001;
        @(negedge clk);
        wait_valid("rst_mid");
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_data", 32'(out_data), 32'h0);
        check("rst_mid_id", 32'(out_id), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        cfg_write(1, 0, 32'h0000_0123);
        cfg_write(2, 0, 32'h0001_0000);
        txn(4'b0110, 1, 16'hB123, "post_rst_rr");
        txn(4'b0100, 2, 16'h0800, "post_rst_d2");

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sobol_fp16_scheduler.md
# sobol_fp16_scheduler

Shares one Sobol step engine and one INT32→FP16 conversion stage among NUM_REQ requesters, each owning an independent Sobol dimension. Round-robin arbitration picks a requester, advances that dimension's Gray-code Sobol state by one point, converts the 32-bit point to the 4-bit-exponent / 12-bit-mantissa unsigned FP16 format, and returns it with a valid/ready handshake. Direction vectors are loaded through a config write port. Sits between the stochastic-computing consumers and the sample source.

## Interface
- NUM_REQ, 4, number of requesters = number of Sobol dimensions (2..8)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- cfg_we  in  1  write direction vector v[cfg_dim][cfg_idx] = cfg_vec
- cfg_dim  in  $clog2(NUM_REQ)  target dimension for write/rewind
- cfg_idx  in  5  direction vector index 0..31
- cfg_vec  in  32  direction vector value
- cfg_rewind  in  1  reset counter n and point x of cfg_dim to 0
- req  in  NUM_REQ  level request per requester
- busy  out  1  a transaction is in flight (STEP or OUT)
- out_valid  out  1  sample available
- out_ready  in  1  consumer accepts sample
- out_id  out  $clog2(NUM_REQ)  requester the sample belongs to
- out_data  out  16  FP16 sample {exp[3:0], mant[11:0]}

## Operation
- Per dimension d: 32-bit counter n_d, 32-bit point x_d, 32×32-bit vectors v_d[0..31]. All reset to 0.
- Step: c = index of lowest 0 bit of n_d; x_d ← x_d ^ v_d[c]; n_d ← n_d+1. If n_d = 0xFFFF_FFFF (no 0 bit): x_d ← 0, n_d ← 0 (wrap, no output-value XOR).
- Conversion (combinational on stepped x): MSO = highest set bit index if ≥12, else 11; exp = MSO[3:0]; mant = x[MSO -: 12].
- FSM: IDLE → (any req) STEP → OUT → (out_valid & out_ready) IDLE.
  - IDLE: grant g = first set req at or after rr_ptr (wrapping); latch g. No req → stay.
  - STEP: perform step on dimension g; register out_data = FP16(new x_g), out_id = g.
  - OUT: out_valid=1, out_data/out_id stable until handshake; on handshake rr_ptr ← (g+1) mod NUM_REQ.
- Requester holds req until it sees a handshake with its out_id; dropping req after grant does not cancel the transaction.
- cfg_we accepted any cycle; a write to v_g[c] in the STEP cycle is not seen by that step (uses old value).
- cfg_rewind on dimension g in the STEP cycle: rewind wins (n_g, x_g = 0); the already-computed sample is still delivered.
- cfg_we and cfg_rewind same cycle: both applied.
- rst mid-transaction: return to IDLE, drop pending sample, all state to reset values.

## Timing
- Reset values: out_valid 0, out_id 0, out_data 0x0000, busy 0, rr_ptr 0, state IDLE.
- req sampled in IDLE at cycle t → out_valid rises at t+2; busy high t+1 until handshake cycle inclusive.
- Handshake at cycle h → IDLE at h+1 → next out_valid no earlier than h+3. Throughput ≤ 1 sample / 3 cycles.
- out_valid never drops without handshake (except rst).

## Structure
- Package sobol_pkg: state enum {IDLE, STEP, OUT}, VEC_W=32, VEC_CNT=32, FP16_W=16, EXP_W=4, MANT_W=12.
- Sub-module rr_arbiter (NUM_REQ-wide, pointer input, one-hot + index output). Step engine and conversion stay inline.

## Test plan
- Dim0 v[0]=0x8000_0000, v[1]=0x4000_0000; three req[0] transactions → out_data 0xF800, 0xFC00, 0xE800, out_id 0.
- req=4'b1111 held continuously → out_id sequence 0,1,2,3,0; each out_valid exactly 2 cycles after IDLE sample.
- out_ready held low 5 cycles in OUT → out_data/out_id stable, busy high, no step on any dimension.
- Point 0x0000_0123 (v[0]=0x123) → out_data 0xB123; cfg_rewind dim0 then request → 0xB123 again.
- cfg_rewind same cycle as STEP on that dim → sample delivered, next request restarts from x=v[0].
- rst asserted in OUT → next cycle out_valid 0, out_data 0x0000, rr_ptr 0; first post-reset req[2] gives first point of dim2.
